aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES encryption controller that drives one combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) once per cycle.
- Owns the 128-bit state register and the round counter. Requests round keys from the external key schedule by index.
- Supports AES-128/192/256 (Nr = 10/12/14).
- Sits between the block-level input/output handshake and the existing round datapath and key-expansion logic.

Parameters:
- NR_MAX, 14, largest round count supported; sizes round counter (4 bits).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  new block + key length offered
- in_ready  out  1  controller can accept a block
- key_len  in  2  00=128, 01=192, 10=256, 11=reserved
- block_in  in  128  plaintext, byte 0 in [127:120]
- abort  in  1  synchronous job cancel
- rk_idx  out  4  round-key index requested from key schedule
- rk_valid  in  1  round key for rk_idx is available this cycle
- rk  in  128  round key for rk_idx
- dp_state  out  128  state presented to round datapath
- dp_last  out  1  final round; datapath bypasses MixColumns
- dp_result  in  128  combinational datapath output for dp_state/rk
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts ciphertext
- block_out  out  128  ciphertext
- cfg_err  out  1  reserved key_len seen on the accepted job

Behaviour:
- Reset values: FSM=IDLE, round=0, state_reg=0, in_ready=1, out_valid=0, dp_last=0, rk_idx=0, cfg_err=0. block_out mirrors state_reg, so it resets to 0.
- Nr decode, latched at accept: 00→10, 01→12, 10→14, 11→10 with cfg_err=1. cfg_err holds until the next accept.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch block_in into state_reg, latch Nr, go to INIT.
  - INIT: rk_idx=0, dp_last=0. On rk_valid: state_reg <= state_reg ^ rk (AddRoundKey performed here, not in the datapath); round <= 1; go to ROUND.
  - ROUND: rk_idx=round, dp_state=state_reg, dp_last=(round==Nr).
    - On rk_valid: state_reg <= dp_result.
    - If round==Nr, go to DONE; else round <= round+1.
    - Without rk_valid: hold state_reg and round, no progress.
  - DONE: out_valid=1, block_out=state_reg. On out_ready, go to IDLE, where in_ready=1 next cycle.
- Latency with rk_valid tied high:
  - Accept edge = cycle 0; INIT = cycle 1; ROUND = cycles 2..Nr+1.
  - out_valid first high in cycle Nr+2: 12/14/16 for AES-128/192/256.
  - Each rk_valid-low cycle adds exactly one cycle.
- Back-to-back: no accept in the DONE→IDLE handoff cycle. Minimum issue interval is Nr+3 cycles when out_ready=1.
- Backpressure: while out_valid && !out_ready, block_out stays stable and in_ready=0.
- abort:
  - In INIT/ROUND/DONE: next state IDLE, out_valid=0, round=0. state_reg holds (not cleared); cfg_err unchanged.
  - In IDLE: no effect, and abort has priority over in_valid that cycle (no accept).
- rst mid-job: same as reset values; any in-flight block is discarded.
- dp_state always equals state_reg. rk_idx equals round in ROUND and 0 in all other states.
- Round counter never exceeds Nr.

Test Plan:
- AES-128: key 000102…0f, block 00112233445566778899aabbccddeeff, rk_valid=1 → block_out 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid at cycle 12; rk_idx sequence 0..10; dp_last high only at rk_idx=10.
- AES-192 (key 000102…17) and AES-256 (key 000102…1f), same block → dda97ca4864cdfe06eaf70a0ec0d7191 at cycle 14 and 8ea2b7ca516745bfeafc49904b496089 at cycle 16.
- Key stall: AES-128 with rk_valid low 3 cycles in ROUND at rk_idx=4 → same ciphertext; out_valid at cycle 15; state_reg and rk_idx frozen during the stall.
- Backpressure: out_ready low 5 cycles in DONE → block_out stable; in_ready=0; a second in_valid is held off and then accepted, producing correct ciphertext.
- abort at cycle 6, and separately rst at cycle 6 → IDLE next cycle, out_valid never asserted. A fresh AES-128 job after each completes correctly in 12 cycles.
- key_len=11 → cfg_err=1, 10 rounds, AES-128 result. The next job with key_len=00 clears cfg_err at accept.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer: owns the state register and round
// counter, steps an external round datapath once per accepted round key.
module aes_round_sequencer #(
  parameter int NR_MAX = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   key_len,
  input  logic [127:0] block_in,
  input  logic         abort,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] block_out,
  output logic         cfg_err
);

  localparam logic [3:0] NR_256 = 4'(NR_MAX);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    ROUND,
    DONE
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic [127:0] state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         dp_last_q, dp_last_d;
  logic         cfg_err_q, cfg_err_d;
  logic [3:0]   nr_dec;
  logic         accept;

  always_comb begin
    unique case (key_len)
      2'b00:   nr_dec = 4'd10;
      2'b01:   nr_dec = 4'd12;
      2'b10:   nr_dec = NR_256;
      default: nr_dec = 4'd10;
    endcase
  end

  always_comb begin
    fsm_d     = fsm_q;
    round_d   = round_q;
    nr_d      = nr_q;
    state_d   = state_q;
    cfg_err_d = cfg_err_q;
    accept    = in_valid && in_ready_q && !abort;

    unique case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d   = block_in;
          nr_d      = nr_dec;
          cfg_err_d = (key_len == 2'b11);
          fsm_d     = INIT;
        end
      end
      INIT: begin
        // Initial AddRoundKey is done here; the datapath only does rounds
        if (rk_valid) begin
          state_d = state_q ^ rk;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (rk_valid) begin
          state_d = dp_result;
          if (round_q == nr_q) begin
            fsm_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d   = IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase

    // Cancel keeps state_q and cfg_err_q as they are
    if (abort && fsm_q != IDLE) begin
      fsm_d   = IDLE;
      round_d = 4'd0;
      state_d = state_q;
    end

    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    rk_idx_d    = (fsm_d == ROUND) ? round_d : 4'd0;
    dp_last_d   = (fsm_d == ROUND) && (round_d == nr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      round_q     <= 4'd0;
      nr_q        <= 4'd10;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dp_last_q   <= 1'b0;
      rk_idx_q    <= 4'd0;
      cfg_err_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      nr_q        <= nr_d;
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dp_last_q   <= dp_last_d;
      rk_idx_q    <= rk_idx_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dp_last   = dp_last_q;
  assign rk_idx    = rk_idx_q;
  assign cfg_err   = cfg_err_q;
  assign dp_state  = state_q;
  assign block_out = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies key schedule and round datapath
// from a software AES model and checks outputs every cycle.
module tb_aes_round_sequencer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   key_len;
  logic [127:0] block_in;
  logic         abort;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk;
  logic [127:0] dp_state;
  logic         dp_last;
  logic [127:0] dp_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] block_out;
  logic         cfg_err;

  aes_round_sequencer #(.NR_MAX(14)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .key_len(key_len), .block_in(block_in),
    .abort(abort),
    .rk_idx(rk_idx), .rk_valid(rk_valid), .rk(rk),
    .dp_state(dp_state), .dp_last(dp_last),
    .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .block_out(block_out), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;
  logic [7:0] sb [256];
  logic [255:0] cur_key = '0;
  int cur_nk = 4;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from the field inverse (x^254) plus the affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] r, base, e, t, acc;
    r = 8'h01; base = x; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    t = r; acc = r;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      acc = acc ^ t;
    end
    return acc ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] rkey(input logic [255:0] key, input int nk, input int j);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    if (j < 0 || j > 14) return '0;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sb[s[127 - 8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = b[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  // State after `steps` round keys have been consumed
  function automatic logic [127:0] mpart(input logic [127:0] blk, input logic [255:0] key,
                                         input int nk, input int nr, input int steps);
    logic [127:0] s;
    s = blk;
    for (int j = 0; j < steps; j++) begin
      if (j == 0) s = s ^ rkey(key, nk, 0);
      else s = aes_round(s, rkey(key, nk, j), j == nr);
    end
    return s;
  endfunction

  function automatic int nk_of(input logic [1:0] kl);
    return (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
  endfunction

  function automatic int nr_of(input logic [1:0] kl);
    return (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 10;
  endfunction

  always_comb begin
    rk = rkey(cur_key, cur_nk, int'(rk_idx));
    dp_result = aes_round(dp_state, rk, dp_last);
  end

  // Job-level reference: a job is idle, or has consumed m_steps round keys
  logic         m_active = 1'b0;
  int           m_steps = 0;
  int           m_nr = 10;
  int           m_nk = 4;
  logic [127:0] m_blk = '0;
  logic [255:0] m_key = '0;
  logic [127:0] m_state = '0;
  logic         m_cfg = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_steps  <= 0;
      m_state  <= '0;
      m_cfg    <= 1'b0;
    end else if (m_active && abort) begin
      m_active <= 1'b0;
      m_steps  <= 0;
    end else if (!m_active) begin
      if (in_valid && !abort) begin
        m_active <= 1'b1;
        m_steps  <= 0;
        m_blk    <= block_in;
        m_key    <= cur_key;
        m_nk     <= nk_of(key_len);
        m_nr     <= nr_of(key_len);
        m_cfg    <= (key_len == 2'b11);
        m_state  <= block_in;
      end
    end else if (m_steps <= m_nr) begin
      if (rk_valid) begin
        m_steps <= m_steps + 1;
        m_state <= mpart(m_blk, m_key, m_nk, m_nr, m_steps + 1);
      end
    end else if (out_ready) begin
      m_active <= 1'b0;
      m_steps  <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 128'(in_ready), 128'(!m_active));
      chk("out_valid", 128'(out_valid), 128'(m_active && m_steps == m_nr + 1));
      chk("rk_idx", 128'(rk_idx),
          (m_active && m_steps >= 1 && m_steps <= m_nr) ? 128'(m_steps) : 128'(0));
      chk("dp_last", 128'(dp_last), 128'(m_active && m_steps == m_nr));
      chk("dp_state", dp_state, m_state);
      chk("block_out", block_out, m_state);
      chk("cfg_err", 128'(cfg_err), 128'(m_cfg));
    end
  end

  task automatic offer(input logic [255:0] key, input logic [1:0] kl, input logic [127:0] blk);
    int guard;
    cur_key  = key;
    cur_nk   = nk_of(kl);
    key_len  = kl;
    block_in = blk;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_job(input logic [127:0] exp_ct, input int exp_lat,
                            input int stall_n, input int bp_n);
    int cnt, stalls, bp, nr;
    logic seen, done;
    logic [127:0] saved;
    cnt = 1; stalls = 0; bp = 0; seen = 0; done = 0; saved = '0;
    nr = exp_lat - 2 - stall_n;
    while (!done && cnt < 200) begin
      rk_valid = !(stalls < stall_n && rk_idx == 4'd4);
      if (!rk_valid) begin
        if (stalls == 0) saved = dp_state;
        else chk("stall_hold", dp_state, saved);
        stalls++;
      end
      if (stall_n == 0 && cnt <= nr + 1) begin
        chk("rk_seq", 128'(rk_idx), 128'(cnt - 1));
        chk("last_seq", 128'(dp_last), 128'(cnt == nr + 1));
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          chk("latency", 128'(cnt), 128'(exp_lat));
        end
        chk("ciphertext", block_out, exp_ct);
        if (bp < bp_n) begin
          out_ready = 1'b0;
          chk("in_ready_bp", 128'(in_ready), 128'(0));
          bp++;
        end else begin
          out_ready = 1'b1;
          done = 1;
        end
      end
      @(posedge clk); #1;
      cnt++;
    end
    rk_valid = 1'b1;
    if (!done) chk("job_timeout", 128'(cnt), 128'(exp_lat));
  endtask

  task automatic kill_at_6(input logic use_rst);
    offer(K128, 2'b00, PT);
    repeat (5) begin @(posedge clk); #1; end
    if (use_rst) rst = 1'b1;
    else abort = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    abort = 1'b0;
    chk(use_rst ? "rst_idle" : "abort_idle", 128'(in_ready), 128'(1));
    repeat (16) begin
      chk("no_out", 128'(out_valid), 128'(0));
      @(posedge clk); #1;
    end
    offer(K128, 2'b00, PT);
    finish_job(CT128, 12, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    rst = 1'b1; in_valid = 1'b0; key_len = 2'b00; block_in = '0;
    abort = 1'b0; rk_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(0));
    chk("rst_dp_last", 128'(dp_last), 128'(0));
    chk("rst_cfg_err", 128'(cfg_err), 128'(0));
    chk("rst_block_out", block_out, 128'(0));

    chk("model128", mpart(PT, K128, 4, 10, 11), CT128);
    chk("model192", mpart(PT, K192, 6, 12, 13), CT192);
    chk("model256", mpart(PT, K256, 8, 14, 15), CT256);

    offer(K128, 2'b00, PT);
    finish_job(CT128, 12, 0, 0);
    offer(K192, 2'b01, PT);
    finish_job(CT192, 14, 0, 0);
    offer(K256, 2'b10, PT);
    finish_job(CT256, 16, 0, 0);

    offer(K128, 2'b00, PT);
    finish_job(CT128, 15, 3, 0);

    offer(K128, 2'b00, PT);
    fork
      finish_job(CT128, 12, 0, 5);
      begin
        int g;
        g = 0;
        while (!out_valid && g < 100) begin @(posedge clk); #1; g++; end
        offer(K256, 2'b10, PT);
      end
    join
    finish_job(CT256, 16, 0, 0);

    in_valid = 1'b1; abort = 1'b1; block_in = 128'hdeadbeef;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_ready", 128'(in_ready), 128'(1));
    chk("idle_abort_hold", block_out, CT256);

    kill_at_6(1'b0);
    kill_at_6(1'b1);

    offer(K128, 2'b11, PT);
    chk("cfg_set", 128'(cfg_err), 128'(1));
    finish_job(CT128, 12, 0, 0);
    chk("cfg_hold", 128'(cfg_err), 128'(1));
    offer(K128, 2'b00, PT);
    chk("cfg_clear", 128'(cfg_err), 128'(0));
    finish_job(CT128, 12, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
